// File: rtl/cpu_pkg.sv
// Shared types and instruction-field helpers for the multi-cycle CPU core.
// Instruction word layout: {op[3:0], rd, rs, imm[DATA_W-1:0]}.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LDI   = 4'h1,
    OP_ADD   = 4'h2,
    OP_SUB   = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_XOR   = 4'h6,
    OP_ADDI  = 4'h7,
    OP_JMP   = 4'h8,
    OP_BEQZ  = 4'h9,
    OP_OUT   = 4'hA,
    OP_RSV_B = 4'hB,
    OP_RSV_C = 4'hC,
    OP_RSV_D = 4'hD,
    OP_RSV_E = 4'hE,
    OP_HALT  = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    EXEC     = 2'd1,
    OUT_WAIT = 2'd2,
    HALT     = 2'd3
  } state_e;

  localparam int OP_W = 4;

  function automatic int instr_width(input int ra_w, input int data_w);
    return OP_W + 2 * ra_w + data_w;
  endfunction

  function automatic int rs_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int rd_lsb(input int ra_w, input int data_w);
    return data_w + ra_w;
  endfunction

  function automatic int op_lsb(input int ra_w, input int data_w);
    return data_w + 2 * ra_w;
  endfunction

  // Ops whose result goes through the ALU into rd, ALUResult and the zero flag.
  function automatic logic alu_writes(input opcode_e op);
    return op inside {OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI};
  endfunction

endpackage

// File: rtl/cpu_multicycle_if.sv
// Bus bundle between the core, its instruction ROM and the output consumer.
// The core is the master: it drives the fetch address and the output channel.
interface cpu_multicycle_if #(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
);

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [DATA_W-1:0]  cpu_out;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output imem_addr,
    output cpu_out,
    output out_valid,
    input  imem_data,
    input  out_ready
  );

  modport slave (
    input  imem_addr,
    input  cpu_out,
    input  out_valid,
    output imem_data,
    output out_ready
  );

endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU: arithmetic wraps modulo 2**DATA_W, LDI passes b through.
// Non-ALU opcodes yield zero; the core does not latch the result for them.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    // NOTE: default assignment first so no path leaves result unassigned (no latch).
    result = '0;
    case (op)
      OP_LDI:           result = b;
      OP_ADD, OP_ADDI:  result = a + b;
      OP_SUB:           result = a - b;
      OP_AND:           result = a & b;
      OP_OR:            result = a | b;
      OP_XOR:           result = a ^ b;
      default:          result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle CPU core: FETCH/EXEC sequencing, register file, branches and a
// valid/ready output channel that stalls the core until the word is taken.
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  cpu_multicycle_if.master  bus,
  output logic [DATA_W-1:0] ALUResult,
  output logic              halted
);

  localparam int RA_W    = $clog2(NREGS);
  localparam int INSTR_W = instr_width(RA_W, DATA_W);
  localparam int RS_LSB  = rs_lsb(DATA_W);
  localparam int RD_LSB  = rd_lsb(RA_W, DATA_W);
  localparam int OP_LSB  = op_lsb(RA_W, DATA_W);

  state_e             state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  regs [NREGS];
  logic               zero_flag;
  logic [DATA_W-1:0]  cpu_out_q;
  logic               out_valid_q;

  opcode_e            op;
  logic [RA_W-1:0]    rd;
  logic [RA_W-1:0]    rs;
  logic [DATA_W-1:0]  imm;
  logic [DATA_W-1:0]  rd_val;
  logic [DATA_W-1:0]  rs_val;
  logic [DATA_W-1:0]  alu_b;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_zero;
  logic [PC_W-1:0]    branch_target;

  assign op            = opcode_e'(ir[OP_LSB +: OP_W]);
  assign rd            = ir[RD_LSB +: RA_W];
  assign rs            = ir[RS_LSB +: RA_W];
  assign imm           = ir[DATA_W-1:0];
  assign rd_val        = regs[rd];
  assign rs_val        = regs[rs];
  assign branch_target = imm[PC_W-1:0];

  // Immediate-form ops feed the immediate into the ALU's second operand.
  assign alu_b = (op == OP_LDI || op == OP_ADDI) ? imm : rs_val;

  cpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op),
    .a      (rd_val),
    .b      (alu_b),
    .result (alu_result),
    .zero   (alu_zero)
  );

  assign bus.imem_addr = pc;
  assign bus.cpu_out   = cpu_out_q;
  assign bus.out_valid = out_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: non-blocking everywhere here so every register samples pre-edge values.
      state       <= FETCH;
      pc          <= '0;
      ir          <= '0;
      zero_flag   <= 1'b0;
      ALUResult   <= '0;
      cpu_out_q   <= '0;
      out_valid_q <= 1'b0;
      halted      <= 1'b0;
      // NOTE: the register file is architecturally cleared by reset, so it is
      // built from resettable flops rather than left to a RAM macro.
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        FETCH: begin
          ir    <= bus.imem_data;
          pc    <= pc + PC_W'(1);
          state <= EXEC;
        end

        EXEC: begin
          state <= FETCH;
          if (alu_writes(op)) begin
            regs[rd]  <= alu_result;
            ALUResult <= alu_result;
            zero_flag <= alu_zero;
          end
          case (op)
            OP_JMP:  pc <= branch_target;
            OP_BEQZ: if (rd_val == '0) pc <= branch_target;
            OP_OUT: begin
              cpu_out_q   <= rd_val;
              out_valid_q <= 1'b1;
              state       <= OUT_WAIT;
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= HALT;
            end
            default: ;
          endcase
        end

        // The word is offered for at least one full cycle, even if the
        // consumer was already ready while the OUT was executing.
        OUT_WAIT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= FETCH;
          end
        end

        HALT: ;

        default: state <= FETCH;
      endcase
    end
  end

  // The zero flag is only ever set by an ALU op whose result, still held in
  // ALUResult, was zero.
  zero_flag_tracks_result: assert property (
    @(posedge clk) disable iff (reset) zero_flag |-> (ALUResult == '0)
  );

endmodule
